// File: rtl/riscv_fetch_unit_pkg.sv
// Shared fetch-stage types: redirect source encoding, fetch buffer entry and FSM states.
package riscv_fetch_unit_pkg;

   typedef logic [31:0] uint32;
   typedef logic [31:0] raw_instr_t;

   typedef enum logic [2:0] {
      PC_PLUS_4 = 3'b000,
      PC_BRANCH = 3'b001,
      PC_JUMP   = 3'b010,
      PC_MTVEC  = 3'b011,
      PC_MEPEC  = 3'b100
   } pc_next_t;

   typedef struct packed {
      raw_instr_t instr;
      uint32      pc;
      logic       misaligned;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_DRAIN = 2'b01,
      ST_HALT  = 2'b10
   } fetch_state_t;

   function automatic logic is_misaligned(input uint32 addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/riscv_fetch_unit_fifo.sv
// Registered in-order buffer of fetch entries with flush; head is read straight from storage.
module fetch_fifo
   import riscv_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t    mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            do_push_s;
   logic            do_pop_s;

   assign empty     = (count_r == CW'(0));
   assign full      = (count_r == CW'(DEPTH));
   assign count     = count_r;
   assign head      = mem_r[rd_ptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Storage, pointers and occupancy; flush discards everything but keeps storage contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, wrong-path drop and misaligned-target marker.
module riscv_fetch_unit
   import riscv_fetch_unit_pkg::*;
#(
   parameter uint32 RESET_PC = 32'h0000_0000,
   parameter int    DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  pc_next_t    pc_next_sel,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output raw_instr_t  instr_raw,
   output logic [31:0] instr_pc,
   output logic        instr_misaligned
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = CW + 1;

   uint32          fpc_r;
   logic [CW-1:0]  outstanding_r;
   logic [CW-1:0]  drop_r;
   fetch_state_t   state_r;
   logic           mis_pend_r;
   logic           req_en_r;
   uint32          pcq_r [DEPTH];
   logic [AW-1:0]  pcq_wr_r;
   logic [AW-1:0]  pcq_rd_r;

   logic           sel_hit_s;
   uint32          target_s;
   logic           take_s;
   logic           pop_s;
   logic           credit_ok_s;
   logic           req_fire_s;
   logic [CW-1:0]  outstanding_nxt_s;
   logic           rsp_keep_s;
   logic           mark_s;
   logic           push_s;
   fetch_entry_t   push_entry_s;
   fetch_entry_t   fifo_head_s;
   logic           fifo_empty_s;
   logic           fifo_full_s;
   logic [CW-1:0]  fifo_count_s;

   // Redirect source decode and the entry written into the buffer
   always_comb begin
      sel_hit_s    = 1'b0;
      target_s     = 32'h0000_0000;
      push_entry_s = '0;
      case (pc_next_sel)
         PC_BRANCH: begin sel_hit_s = 1'b1; target_s = branch_target; end
         PC_JUMP:   begin sel_hit_s = 1'b1; target_s = jump_target;   end
         PC_MTVEC:  begin sel_hit_s = 1'b1; target_s = mtvec;         end
         PC_MEPEC:  begin sel_hit_s = 1'b1; target_s = mepc;          end
         default:   begin sel_hit_s = 1'b0; target_s = 32'h0000_0000; end
      endcase
      if (mark_s) begin
         push_entry_s.instr      = 32'h0000_0000;
         push_entry_s.pc         = fpc_r;
         push_entry_s.misaligned = 1'b1;
      end else begin
         push_entry_s.instr      = imem_rsp_data;
         push_entry_s.pc         = pcq_r[pcq_rd_r];
         push_entry_s.misaligned = 1'b0;
      end
   end

   assign take_s      = redirect_valid && sel_hit_s;
   assign pop_s       = instr_valid && instr_ready;
   // A consumer pop this cycle frees a slot, which keeps one request per cycle flowing at DEPTH=2
   assign credit_ok_s = (SW'(outstanding_r) + SW'(fifo_count_s)) < (SW'(DEPTH) + SW'(pop_s));
   assign imem_req_valid = req_en_r && credit_ok_s;
   assign imem_req_addr  = fpc_r;
   assign req_fire_s  = imem_req_valid && imem_req_ready;
   assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
   assign rsp_keep_s  = imem_rsp_valid && (drop_r == CW'(0)) && !take_s;
   assign mark_s      = mis_pend_r && (drop_r == CW'(0)) && !take_s && !fifo_full_s;
   assign push_s      = rsp_keep_s || mark_s;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (take_s),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .count     (fifo_count_s)
   );

   assign instr_valid      = !fifo_empty_s;
   assign instr_raw        = fifo_head_s.instr;
   assign instr_pc         = fifo_head_s.pc;
   assign instr_misaligned = fifo_head_s.misaligned;

   // Fetch PC, credit/drop counters, request PC queue and RUN/DRAIN/HALT control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc_r         <= RESET_PC;
         outstanding_r <= '0;
         drop_r        <= '0;
         state_r       <= ST_RUN;
         mis_pend_r    <= 1'b0;
         req_en_r      <= 1'b0;
         pcq_wr_r      <= '0;
         pcq_rd_r      <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pcq_r[i] <= 32'h0000_0000;
         end
      end else begin
         outstanding_r <= outstanding_nxt_s;
         if (req_fire_s) begin
            pcq_r[pcq_wr_r] <= fpc_r;
            pcq_wr_r        <= pcq_wr_r + AW'(1);
         end
         // Every response retires its queued PC, whether kept or dropped
         if (imem_rsp_valid) begin
            pcq_rd_r <= pcq_rd_r + AW'(1);
         end
         if (take_s) begin
            fpc_r      <= target_s;
            drop_r     <= outstanding_nxt_s;
            mis_pend_r <= is_misaligned(target_s);
            req_en_r   <= !is_misaligned(target_s);
            state_r    <= (outstanding_nxt_s != CW'(0)) ? ST_DRAIN : ST_RUN;
         end else begin
            if (req_fire_s) begin
               fpc_r <= fpc_r + 32'd4;
            end
            if (imem_rsp_valid && (drop_r != CW'(0))) begin
               drop_r <= drop_r - CW'(1);
            end
            mis_pend_r <= mis_pend_r && !mark_s;
            req_en_r   <= !mark_s && !mis_pend_r && (state_r != ST_HALT);
            case (state_r)
               ST_RUN:   state_r <= mark_s ? ST_HALT : ST_RUN;
               ST_DRAIN: state_r <= (imem_rsp_valid && (drop_r == CW'(1))) ? ST_RUN : ST_DRAIN;
               ST_HALT:  state_r <= ST_HALT;
               default:  state_r <= ST_RUN;
            endcase
         end
      end
   end

endmodule
